// File: rtl/keypad_scanner_if.sv
// Keypad scanner port bundle: matrix lines plus the decoded key outputs.
// Latency: none, wires only.
// Backpressure: none; key_valid is a fire-and-forget strobe and key_code is held.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Scanner side: reads rows, drives columns and the decoded key.
    modport master (
        input  rows,
        output cols,
        output key_code,
        output key_valid,
        output key_held
    );

    // Keypad/consumer side.
    modport slave (
        output rows,
        input  cols,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns, debounces whole frames, emits hex codes.
// Latency: key_valid one cycle after the completing tick of the DEBOUNCE-th consistent frame.
// Backpressure: none; key_valid is a one-cycle strobe, key_code holds until the next acceptance.
module keypad_scanner #(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic               clk,
    input  logic               reset,
    keypad_scanner_if.master   kp
);

    localparam int TW = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    // Frame bit index k = 4*col + row; table lists keys column by column.
    function automatic logic [3:0] key_map(input logic [3:0] k);
        logic [3:0] code;
        case (k)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h4;
            4'd2:    code = 4'h7;
            4'd3:    code = 4'h0;
            4'd4:    code = 4'h2;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h8;
            4'd7:    code = 4'hF;
            4'd8:    code = 4'h3;
            4'd9:    code = 4'h6;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hE;
            4'd12:   code = 4'hA;
            4'd13:   code = 4'hB;
            4'd14:   code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [1:0]    col_idx;
    logic [1:0]    col_nxt;
    logic [3:0]    cols_q;
    logic [3:0]    rows_meta;
    logic [3:0]    rows_sync;
    logic [15:0]   frame;
    logic [15:0]   frame_now;
    logic          frame_done;
    logic [4:0]    ones;
    logic [3:0]    hit_idx;
    logic          cls_single;
    logic          cls_none;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n, cnt_inc;
    logic [3:0]    cand_q, cand_n;
    logic [3:0]    code_q, code_n;
    logic          valid_q, valid_n;
    logic          held_q, held_n;

    assign tick       = (tick_cnt == TW'(SCAN_DIV - 1));
    assign col_nxt    = col_idx + 2'd1;
    assign frame_done = tick && (col_idx == 2'd3);
    assign cnt_inc    = cnt_q + CW'(1);

    // Column dwell timer and registered column drive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
            col_idx  <= 2'd0;
            cols_q   <= 4'b1110;
        end else if (tick) begin
            tick_cnt <= '0;
            col_idx  <= col_nxt;
            cols_q   <= ~(4'b0001 << col_nxt);
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
        end else begin
            rows_meta <= kp.rows;
            rows_sync <= rows_meta;
        end
    end

    // Capture the active column's pressed rows at the end of each dwell.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame <= '0;
        end else if (tick) begin
            frame[{col_idx, 2'b00} +: 4] <= ~rows_sync;
        end
    end

    // Frame including the column being captured now, and its classification.
    always_comb begin
        frame_now = frame;
        frame_now[{col_idx, 2'b00} +: 4] = ~rows_sync;
        ones    = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (frame_now[i]) begin
                ones    = ones + 5'd1;
                hit_idx = 4'(i);
            end
        end
        cls_none   = (ones == 5'd0);
        cls_single = (ones == 5'd1);
    end

    // Debounce FSM and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            cand_q  <= cand_n;
            code_q  <= code_n;
            valid_q <= valid_n;
            held_q  <= held_n;
        end
    end

    // Next-state logic; only a completed frame moves the FSM.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        cand_n  = cand_q;
        code_n  = code_q;
        valid_n = 1'b0;
        held_n  = held_q;
        if (frame_done) begin
            case (state_q)
                S_IDLE: begin
                    if (cls_single) begin
                        cand_n = hit_idx;
                        cnt_n  = CW'(1);
                        if (DEBOUNCE == 1) begin
                            code_n  = key_map(hit_idx);
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            state_n = S_PRESSED;
                        end else begin
                            state_n = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (cls_single && hit_idx == cand_q) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE)) begin
                            code_n  = key_map(cand_q);
                            valid_n = 1'b1;
                            held_n  = 1'b1;
                            state_n = S_PRESSED;
                        end
                    end else if (cls_single) begin
                        cand_n = hit_idx;
                        cnt_n  = CW'(1);
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    // No rollover: anything other than an empty frame keeps the key held.
                    if (cls_none) begin
                        cnt_n = CW'(1);
                        if (DEBOUNCE == 1) begin
                            held_n  = 1'b0;
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_RELEASE;
                        end
                    end
                end
                default: begin
                    if (cls_none) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE)) begin
                            held_n  = 1'b0;
                            state_n = S_IDLE;
                        end
                    end else begin
                        state_n = S_PRESSED;
                    end
                end
            endcase
        end
    end

    assign kp.cols      = cols_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule
